reg_bus_initiator: RTL
======================

Name: reg_bus_initiator

Overview:
- Bus initiator that drives the register-file side of BUS_IF: WEN, OEN, ADDR and DIN out; DOUT in.
- Accepts write and read commands from a local valid/ready command channel.
- Sequences the bus cycles, captures the registered read data and returns it on a valid/ready response channel.
- Sits between a controller or test sequencer and any BUS_IF responder, and supports wrapping read bursts.

Parameters:
- DATA_W, 8, data width of DIN, DOUT, CMD_WDATA and RSP_DATA.
- ADDR_W, 3, address width; the space is 2**ADDR_W registers, and burst addresses wrap modulo 2**ADDR_W.

Ports:
- CLK  in  1  bus clock, shared with the responder.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY at the CLK edge.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  start address.
- CMD_WDATA  in  DATA_W  write data; ignored for reads.
- CMD_LEN  in  ADDR_W  read beats minus 1 (0..7); ignored for writes.
- RSP_VALID  out  1  read data available.
- RSP_READY  in  1  consumer takes the data.
- RSP_DATA  out  DATA_W  read data.
- RSP_LAST  out  1  final beat of a burst.
- ERR  out  1  sticky readback-mismatch flag; tied 0 without the optional feature.
- WEN  out  1  to BUS_IF.WEN.
- OEN  out  1  to BUS_IF.OEN.
- ADDR  out  ADDR_W  to BUS_IF.ADDR.
- DIN  out  DATA_W  to BUS_IF.DIN.
- DOUT  in  DATA_W  from BUS_IF.DOUT; the responder registers it on the CLK edge where OEN is high.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RST_N).
  - RST_N low immediately forces all outputs to 0 (CMD_READY, RSP_*, ERR, WEN, OEN, ADDR, DIN), state IDLE, beat counter 0.
  - Reset mid-transaction abandons it; no response is produced after release.
- Outputs: all are registered, with no combinational path from inputs to outputs.
- FSM states: IDLE, WR_DRIVE, RD_DRIVE, RD_CAPT, RD_RESP.
- IDLE:
  - CMD_READY=1, WEN=OEN=0.
  - On accept: latch ADDR=CMD_ADDR.
  - Write: DIN=CMD_WDATA, go to WR_DRIVE.
  - Read: latch beats_left=CMD_LEN, go to RD_DRIVE.
- WR_DRIVE:
  - WEN=1 for exactly one cycle; the responder writes at the next edge.
  - Then go to IDLE; writes produce no response.
  - Write-to-next-accept spacing is 2 cycles.
- RD_DRIVE: OEN=1 for exactly one cycle, then go to RD_CAPT.
- RD_CAPT:
  - OEN=0; DOUT is now valid and stable.
  - At the edge, RSP_DATA<=DOUT, RSP_VALID<=1, RSP_LAST<=(beats_left==0); go to RD_RESP.
- RD_RESP:
  - Hold RSP_VALID, RSP_DATA and RSP_LAST stable until RSP_READY.
  - On handshake: RSP_VALID<=0.
  - If beats_left==0: go to IDLE.
  - Otherwise: ADDR<=ADDR+1 (wraps 7->0), beats_left-=1, go to RD_DRIVE.
- Read latency: accept at edge 0, OEN high in cycle 0-1, RSP_VALID rises at edge 2.
  - With RSP_READY held high, each beat takes 3 cycles.
- Invariants:
  - WEN and OEN are never high in the same cycle.
  - CMD_READY is 0 in every state except IDLE.
- CMD_LEN=7 starting at ADDR 5 reads 5,6,7,0,1,2,3,4.

Optional Feature:
- Macro READBACK_VERIFY_EN.
- When defined:
  - WR_DRIVE goes to RD_DRIVE at the same address instead of IDLE.
  - RD_CAPT compares DOUT to the latched DIN; a mismatch sets ERR (sticky until reset).
  - No response is issued for the verify read; then go to IDLE.
  - Write spacing becomes 4 cycles.
- When undefined: no verify path, ERR tied 0.

Decomposition:
- Package reg_bus_pkg holds:
  - DATA_W and ADDR_W defaults.
  - The state enum (IDLE, WR_DRIVE, RD_DRIVE, RD_CAPT, RD_RESP).
  - A cmd_t struct {write, addr, wdata, len} for benches and sequencers.
- Single module; no sub-module needed.
- Top level connects WEN/OEN/ADDR/DIN/DOUT to the BUS_IF instance shared with REG-file responders.

Test Plan:
- Write 0xA5 to addr 3, then read addr 3 with LEN=0 -> WEN high for exactly 1 cycle with ADDR=3, DIN=0xA5; RSP_DATA=0xA5, RSP_LAST=1, RSP_VALID at edge 2 after the read accept.
- Write addr k with 0x10+k for k=0..7, then read burst ADDR=5, LEN=7 -> responses 0x15,0x16,0x17,0x10,0x11,0x12,0x13,0x14; RSP_LAST only on the 8th beat.
- Read burst LEN=2 with RSP_READY low for 5 cycles on beat 1 -> RSP_DATA/RSP_VALID held stable; no OEN pulse until the handshake; CMD_READY stays 0.
- Assert RST_N low during RD_CAPT of a LEN=3 burst -> all outputs 0 in the same cycle; after release CMD_READY=1 and no stray RSP_VALID.
- Back-to-back writes with CMD_VALID held high -> accept every 2 cycles (4 with READBACK_VERIFY_EN); WEN and OEN never both high.
- READBACK_VERIFY_EN, with the responder model forcing DOUT=0x00 after a write of 0x3C -> ERR=1 and stays 1; no RSP_VALID for the verify read.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and default widths for the register-bus initiator and its sequencers.
package reg_bus_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR_DRIVE,
        RD_DRIVE,
        RD_CAPT,
        RD_RESP
    } state_e;

    typedef struct packed {
        logic                      write;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
        logic [DEFAULT_ADDR_W-1:0] len;
    } cmd_t;

endpackage

// File: rtl/reg_bus_initiator.sv
// BUS_IF initiator: sequences single writes and wrapping read bursts from a command channel.
// Define READBACK_VERIFY_EN to re-read every write and flag mismatches on ERR.
module reg_bus_initiator
    import reg_bus_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    input  logic [ADDR_W-1:0] CMD_LEN,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_LAST,
    output logic              ERR,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DIN,
    input  logic [DATA_W-1:0] DOUT
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   beats_left_q, beats_left_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_last_q, rsp_last_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                wen_q, wen_d;
    logic                oen_q, oen_d;
    logic                cmd_accept;
`ifdef READBACK_VERIFY_EN
    logic                verify_q, verify_d;
    logic                err_q, err_d;
`endif

    // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        din_d        = din_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_last_d   = rsp_last_q;
        cmd_accept   = cmd_ready_q && CMD_VALID;
`ifdef READBACK_VERIFY_EN
        verify_d     = verify_q;
        err_d        = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    addr_d = CMD_ADDR;
                    if (CMD_WRITE) begin
                        din_d   = CMD_WDATA;
                        state_d = WR_DRIVE;
                    end else begin
                        beats_left_d = CMD_LEN;
                        state_d      = RD_DRIVE;
                    end
                end
            end
            WR_DRIVE: begin
`ifdef READBACK_VERIFY_EN
                verify_d = 1'b1;
                state_d  = RD_DRIVE;
`else
                state_d  = IDLE;
`endif
            end
            RD_DRIVE: state_d = RD_CAPT;
            RD_CAPT: begin
`ifdef READBACK_VERIFY_EN
                if (verify_q) begin
                    // Verify reads are internal: they only update the sticky error.
                    if (DOUT != din_q) err_d = 1'b1;
                    verify_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    rsp_data_d  = DOUT;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (beats_left_q == '0);
                    state_d     = RD_RESP;
                end
`else
                rsp_data_d  = DOUT;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (beats_left_q == '0);
                state_d     = RD_RESP;
`endif
            end
            RD_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    if (beats_left_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d       = addr_q + ADDR_W'(1);
                        beats_left_d = beats_left_q - ADDR_W'(1);
                        state_d      = RD_DRIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up exactly with it.
        cmd_ready_d = (state_d == IDLE);
        wen_d       = (state_d == WR_DRIVE);
        oen_d       = (state_d == RD_DRIVE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            din_q        <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_last_q   <= 1'b0;
            cmd_ready_q  <= 1'b0;
            wen_q        <= 1'b0;
            oen_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            din_q        <= din_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_last_q   <= rsp_last_d;
            cmd_ready_q  <= cmd_ready_d;
            wen_q        <= wen_d;
            oen_q        <= oen_d;
        end
    end

`ifdef READBACK_VERIFY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            verify_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            verify_q <= verify_d;
            err_q    <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign CMD_READY = cmd_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_LAST  = rsp_last_q;
    assign WEN       = wen_q;
    assign OEN       = oen_q;
    assign ADDR      = addr_q;
    assign DIN       = din_q;

endmodule
